// File: rtl/data_sram_responder.sv
// data_sram_responder: single-outstanding SRAM-like slave with byte-lane writes and fixed response delay
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int RESP_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic HAS_WAIT = RESP_DELAY > 0;
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(RESP_DELAY - 1) : 4'd0;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next_state;
  logic [3:0] cnt, next_cnt;
  logic [31:0] resp_q;
  logic [31:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic accept;
  logic unused;
  assign unused = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:ADDR_WIDTH+2]};
  assign idx = data_sram_addr[ADDR_WIDTH+1:2];
  assign data_sram_addr_ok = resetn && state == IDLE;
  assign accept = data_sram_req && data_sram_addr_ok;
  assign data_sram_data_ok = resetn && state == RESP;
  assign data_sram_rdata = data_sram_data_ok ? resp_q : 32'h0;
  // next-state and delay-counter logic
  always_comb begin
    next_state = state;
    next_cnt = cnt;
    if (accept) begin
      next_state = HAS_WAIT ? WAIT : RESP;
      next_cnt = CNT_INIT;
    end else if (state == WAIT) begin
      next_state = cnt == 4'd0 ? RESP : WAIT;
      next_cnt = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end else if (state == RESP) begin
      next_state = IDLE;
    end
  end
  // state, counter and response register; writes yield a zero response word
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= 4'd0;
      resp_q <= 32'h0;
    end else begin
      state <= next_state;
      cnt <= next_cnt;
      if (accept) resp_q <= data_sram_wr ? 32'h0 : mem[idx];
    end
  end
  // storage commits writes on the accept edge and is never cleared by reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (accept && data_sram_wr && data_sram_wstrb[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
  end
endmodule
